// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution stage: conditional-branch
// funct3 encodings, the sequential PC step and the resolved-result record
// that travels through the result FIFO.
// -----------------------------------------------------------------------------
package branch_pkg;

  // Conditional-branch funct3 encodings (010/011 are reserved).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Fall-through distance for a not-taken branch.
  localparam int PC_STEP = 4;

  // Widest datapath the result record can carry. Narrower cores keep the
  // target in the low XLEN bits; the upper bits are constant zero and vanish
  // in synthesis.
  localparam int MAX_XLEN = 64;

  typedef struct packed {
    logic                taken;
    logic [MAX_XLEN-1:0] target;
    logic                mispredict;
    logic                illegal;
  } branch_result_t;

endpackage : branch_pkg

// File: rtl/branch_eval.sv
// -----------------------------------------------------------------------------
// branch_eval
// Purely combinational branch evaluation: operand compare, funct3 decode,
// jump override, next-PC target and misprediction flag.
//
// Ports
//   rs1, rs2    in   XLEN  operands
//   funct3      in   3     branch condition
//   is_jump     in   1     JAL/JALR, forces taken
//   pc          in   XLEN  PC of the branch
//   imm         in   XLEN  sign-extended offset
//   pred_taken  in   1     front-end direction guess
//   result      out  rec   {taken, target, mispredict, illegal}
// -----------------------------------------------------------------------------
module branch_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32  // must not exceed MAX_XLEN
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic            is_jump,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  output branch_result_t  result
);

  logic            eq;
  logic            lt;
  logic            ltu;
  logic            taken;
  logic            illegal;
  logic [XLEN-1:0] target;

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    eq      = (rs1 == rs2);
    lt      = ($signed(rs1) < $signed(rs2));
    ltu     = (rs1 < rs2);
    taken   = 1'b0;
    illegal = 1'b0;

    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: illegal = 1'b1;  // reserved encodings resolve as not taken
    endcase

    if (is_jump) begin
      taken   = 1'b1;
      illegal = 1'b0;
    end

    // Both sums wrap naturally at XLEN bits.
    target = taken ? (pc + imm) : (pc + XLEN'(PC_STEP));

    result                   = '0;
    result.taken             = taken;
    result.target[XLEN-1:0]  = target;
    result.mispredict        = taken ^ pred_taken;
    result.illegal           = illegal;
  end

endmodule : branch_eval

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Branch resolution stage between execute and PC-redirect/retire. Each
// accepted request is evaluated by branch_eval and the result is queued in a
// DEPTH-entry FIFO (1-cycle latency, no bypass). Retired mispredictions are
// counted in a saturating counter.
//
// Ports
//   Clk               in   1      clock, rising edge
//   Reset_n           in   1      synchronous active-low reset
//   In_Valid/Ready    in/out 1    request handshake
//   Rs1_Data,Rs2_Data in   XLEN   operands
//   Branch_Funct3     in   3      branch condition
//   Is_Jump           in   1      unconditional jump
//   Pc, Imm           in   XLEN   branch PC and offset
//   Pred_Taken        in   1      front-end prediction
//   Flush             in   1      discard all buffered results
//   Out_Valid/Ready   out/in 1    result handshake
//   Taken, Target     out  1/XLEN resolved direction and next PC
//   Mispredict        out  1      Taken != Pred_Taken
//   Illegal           out  1      reserved funct3 seen
//   Mispredict_Count  out  CNT_W  retired mispredictions, saturating
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,   // 1..4, need not be a power of two
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [XLEN-1:0]  Rs1_Data,
  input  logic [XLEN-1:0]  Rs2_Data,
  input  logic [2:0]       Branch_Funct3,
  input  logic             Is_Jump,
  input  logic [XLEN-1:0]  Pc,
  input  logic [XLEN-1:0]  Imm,
  input  logic             Pred_Taken,
  input  logic             Flush,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Taken,
  output logic [XLEN-1:0]  Target,
  output logic             Mispredict,
  output logic             Illegal,
  output logic [CNT_W-1:0] Mispredict_Count
);

  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W  = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);

  branch_result_t      eval_result;
  branch_result_t      mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [COUNT_W-1:0]  count;
  logic                push;
  logic                pop;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  branch_eval #(
    .XLEN (XLEN)
  ) u_eval (
    .rs1        (Rs1_Data),
    .rs2        (Rs2_Data),
    .funct3     (Branch_Funct3),
    .is_jump    (Is_Jump),
    .pc         (Pc),
    .imm        (Imm),
    .pred_taken (Pred_Taken),
    .result     (eval_result)
  );

  // Ready looks only at the stored count, never at Out_Ready, so a full FIFO
  // stays closed even in a cycle where the head is being popped.
  assign In_Ready  = Reset_n && (count < FULL_CNT);
  assign Out_Valid = (count != '0);

  // Flush wins over both handshakes in the same cycle.
  assign push = In_Valid && In_Ready && !Flush;
  assign pop  = Out_Valid && Out_Ready && !Flush;

  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // the outputs are zeroed while empty, so stale contents are never visible.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= eval_result;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;  // idle or push+pop: occupancy unchanged
      endcase
    end
  end

  // Counts mispredictions as they retire (pop), not as they are resolved.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Mispredict_Count <= '0;
    end else if (pop && mem[rd_ptr].mispredict && (Mispredict_Count != '1)) begin
      Mispredict_Count <= Mispredict_Count + 1'b1;
    end
  end

  // Head data is gated to zero while the FIFO is empty.
  assign Taken      = Out_Valid && mem[rd_ptr].taken;
  assign Target     = Out_Valid ? XLEN'(mem[rd_ptr].target) : '0;
  assign Mispredict = Out_Valid && mem[rd_ptr].mispredict;
  assign Illegal    = Out_Valid && mem[rd_ptr].illegal;

endmodule : branch_resolve_unit

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage for the pipelined RISC-V core, the successor to the single-cycle combinational comparator. It decodes the full conditional-branch funct3 set plus unconditional jumps and computes the next-PC target. It flags mispredictions against the front-end guess and buffers resolved results in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It sits between execute and the PC-redirect/retire logic and keeps a saturating mispredict counter.

## Interface
- XLEN, 32, datapath and PC width
- DEPTH, 2, result FIFO entries (1..4)
- CNT_W, 16, mispredict counter width
- Clk  in  1  clock, all state on rising edge
- Reset_n  in  1  synchronous, active-low reset
- In_Valid  in  1  request valid
- In_Ready  out  1  unit can accept a request
- Rs1_Data  in  XLEN  operand 1
- Rs2_Data  in  XLEN  operand 2
- Branch_Funct3  in  3  branch condition
- Is_Jump  in  1  JAL/JALR, unconditionally taken
- Pc  in  XLEN  PC of the branch
- Imm  in  XLEN  sign-extended offset (for JALR: precomputed base-relative offset)
- Pred_Taken  in  1  front-end prediction
- Flush  in  1  discard all buffered results
- Out_Valid  out  1  result valid
- Out_Ready  in  1  consumer accepts the result
- Taken  out  1  resolved direction
- Target  out  XLEN  next PC
- Mispredict  out  1  Taken != Pred_Taken
- Illegal  out  1  reserved funct3 seen
- Mispredict_Count  out  CNT_W  retired mispredictions, saturating

## Operation
- Compare: eq = (Rs1==Rs2); lt = signed less-than; ltu = unsigned less-than.
- Funct3 decode:
  - 000 BEQ: eq
  - 001 BNE: !eq
  - 100 BLT: lt
  - 101 BGE: !lt
  - 110 BLTU: ltu
  - 111 BGEU: !ltu
  - 010/011: Taken=0, Illegal=1
- Is_Jump=1 overrides the decode: Taken=1, Illegal=0.
- Target:
  - Taken: Pc+Imm, modulo 2^XLEN.
  - Not taken: Pc+4, modulo 2^XLEN.
- Mispredict = Taken ^ Pred_Taken. An illegal entry is treated as not taken for this comparison.
- Push: on In_Valid && In_Ready, the evaluated entry {Taken, Target, Mispredict, Illegal} is written at the tail.
- Pop: on Out_Valid && Out_Ready, the head is removed. If the popped entry has Mispredict=1, Mispredict_Count increments, saturating at 2^CNT_W-1.
- Status signals: In_Ready = Reset_n && (count < DEPTH). Out_Valid = (count != 0).
- Out data fields are driven to 0 whenever Out_Valid=0.
- Flush: count and pointers clear next edge. A push or pop in the same cycle is ignored. Mispredict_Count is unaffected.

## Timing
- Latency is 1 cycle: a request accepted at edge N is visible on Out_Valid after edge N. There is no combinational input-to-output path.
- Reset (Reset_n=0 at an edge), all next-edge values:
  - count=0, pointers=0
  - Out_Valid=0, Taken/Target/Mispredict/Illegal=0
  - Mispredict_Count=0
  - In_Ready=0 while Reset_n is low
- Reset mid-operation drops all entries with no partial output.
- Full (count==DEPTH): In_Ready=0 even if a pop occurs in the same cycle (no pass-through).
- Simultaneous push and pop at 0<count<DEPTH: count unchanged, both complete.
- Empty with push: Out_Valid rises next cycle. There is no same-cycle bypass.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Out_Valid and the head data stay stable until Out_Ready is sampled high.

## Structure
- Package branch_pkg holds:
  - funct3 constants (F3_BEQ…F3_BGEU)
  - branch_result_t struct {taken, target, mispredict, illegal}
  - PC_STEP = 4
- Sub-module branch_eval: purely combinational compare, decode and target calculation, XLEN-parametrised.
- The top module holds the FIFO storage, count/pointer logic and counter.

## Test plan
- Rs1=0x80000000, Rs2=0x1, funct3=100, Pc=0x100, Imm=0xFFFFFFF0, Pred=0 -> Taken=1, Target=0xF0, Mispredict=1; counter becomes 1 after pop.
- Same operands with funct3=110, Pred=0 -> Taken=0, Target=0x104, Mispredict=0.
- funct3=011 -> Illegal=1, Taken=0. Is_Jump=1 with funct3=011 -> Taken=1, Illegal=0.
- Hold Out_Ready=0 and push DEPTH=2 entries -> In_Ready=0. A third push is stalled, and FIFO order is preserved once Out_Ready=1.
- Fill the FIFO, then Flush=1 with In_Valid=1 -> next cycle Out_Valid=0, count=0, the flushed-cycle input is dropped, and the counter is unchanged.
- CNT_W=2, pop 5 mispredicted entries -> Mispredict_Count saturates at 3. Then Reset_n=0 for one edge -> all outputs 0.
